// File: rtl/op_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : op_encoder
//  Brief    : Synchronises and debounces the calculator push-buttons and
//             produces a registered 2-bit op_sel with a one-cycle op_valid.
//             Optional OP_CYCLE_EN adds btn_next (op_sel increments mod 4).
//  Revision : 1.0 - initial release
// ============================================================================
module op_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_mul2,
    input  logic       btn_div2,
`ifdef OP_CYCLE_EN
    input  logic       btn_next,
`endif
    output logic [1:0] op_sel,
    output logic       op_valid,
    output logic       multi_err,
    output logic       busy
);

`ifdef OP_CYCLE_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_sync1;
    logic [NB-1:0]    r_btn_s;

    state_t           r_state;
    state_t           w_state_nx;
    logic [NB-1:0]    r_cand;
    logic [NB-1:0]    w_cand_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [1:0]       r_op_sel;
    logic [1:0]       w_op_sel_nx;
    logic [1:0]       w_code;
    logic             r_op_valid;
    logic             w_valid_nx;
    logic             r_multi_err;
    logic             w_multi;
    logic             w_onehot;
    logic             r_busy;

`ifdef OP_CYCLE_EN
    assign w_raw = {btn_next, btn_div2, btn_mul2, btn_sub, btn_add};
`else
    assign w_raw = {btn_div2, btn_mul2, btn_sub, btn_add};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_btn_s <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_btn_s <= r_sync1;
        end
    end

    // x & (x-1) clears the lowest set bit: nonzero means two or more bits set
    assign w_multi  = (r_btn_s & (r_btn_s - NB'(1))) != '0;
    assign w_onehot = (r_btn_s != '0) && !w_multi;

    always_comb begin
        w_code = r_op_sel;
        if (r_cand[0])      w_code = 2'b00;
        else if (r_cand[1]) w_code = 2'b01;
        else if (r_cand[2]) w_code = 2'b10;
        else if (r_cand[3]) w_code = 2'b11;
`ifdef OP_CYCLE_EN
        else if (r_cand[4]) w_code = r_op_sel + 2'd1;
`endif
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cand_nx   = r_cand;
        w_cnt_nx    = r_cnt;
        w_op_sel_nx = r_op_sel;
        w_valid_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_cand_nx  = r_btn_s;
                    w_cnt_nx   = '0;
                    w_state_nx = S_PRESS;
                end
            end
            S_PRESS: begin
                if (r_btn_s == r_cand) begin
                    if (r_cnt == c_LAST) begin
                        w_state_nx  = S_HOLD;
                        w_op_sel_nx = w_code;
                        w_valid_nx  = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_btn_s == '0) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (r_btn_s == '0) begin
                    if (r_cnt == c_LAST) w_state_nx = S_IDLE;
                    else                 w_cnt_nx   = r_cnt + 1'b1;
                end else begin
                    w_state_nx = S_HOLD;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_op_sel    <= 2'b00;
            r_op_valid  <= 1'b0;
            r_multi_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cand      <= w_cand_nx;
            r_cnt       <= w_cnt_nx;
            r_op_sel    <= w_op_sel_nx;
            r_op_valid  <= w_valid_nx;
            r_multi_err <= (r_state == S_IDLE) && w_multi;
            r_busy      <= (w_state_nx != S_IDLE);
        end
    end

    assign op_sel    = r_op_sel;
    assign op_valid  = r_op_valid;
    assign multi_err = r_multi_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_op_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_op_encoder
//  Brief    : Directed self-checking bench for op_encoder (DEBOUNCE_CYCLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_op_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_add = 1'b0;
    logic       btn_sub = 1'b0;
    logic       btn_mul2 = 1'b0;
    logic       btn_div2 = 1'b0;
`ifdef OP_CYCLE_EN
    logic       btn_next = 1'b0;
`endif
    logic [1:0] op_sel;
    logic       op_valid;
    logic       multi_err;
    logic       busy;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;
    int p0     = 0;

    op_encoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_add  (btn_add),
        .btn_sub  (btn_sub),
        .btn_mul2 (btn_mul2),
        .btn_div2 (btn_div2),
`ifdef OP_CYCLE_EN
        .btn_next (btn_next),
`endif
        .op_sel   (op_sel),
        .op_valid (op_valid),
        .multi_err(multi_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (op_valid === 1'b1) pulses <= pulses + 1;

    // n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset
        tick(3);
        check("rst_op_sel", 32'(op_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_op_sel", 32'(op_sel), 32'd0);
        check("post_rst_valid", 32'(op_valid), 32'd0);
        check("post_rst_multi", 32'(multi_err), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 2. btn_sub held 20 cycles (edges 0..19)
        p0 = pulses;
        btn_sub = 1'b1;
        tick(6);                                  // after edge 5
        check("sub_e5_valid", 32'(op_valid), 32'd0);
        check("sub_e5_sel", 32'(op_sel), 32'd0);
        check("sub_e5_busy", 32'(busy), 32'd1);
        tick(1);                                  // after edge 6
        check("sub_e6_valid", 32'(op_valid), 32'd1);
        check("sub_e6_sel", 32'(op_sel), 32'd1);
        tick(1);                                  // after edge 7
        check("sub_e7_valid", 32'(op_valid), 32'd0);
        tick(12);                                 // after edge 19
        btn_sub = 1'b0;
        tick(10);
        check("sub_pulses", 32'(pulses - p0), 32'd1);
        check("sub_idle_busy", 32'(busy), 32'd0);

        // 3. btn_mul2 glitch, 3 cycles
        p0 = pulses;
        btn_mul2 = 1'b1;
        tick(3);                                  // after edge 2
        check("mul_busy", 32'(busy), 32'd1);
        btn_mul2 = 1'b0;
        tick(6);
        check("mul_pulses", 32'(pulses - p0), 32'd0);
        check("mul_sel", 32'(op_sel), 32'd1);
        check("mul_busy_end", 32'(busy), 32'd0);

        // 4. add+div2 together, then div2 alone
        p0 = pulses;
        btn_add  = 1'b1;
        btn_div2 = 1'b1;
        tick(4);                                  // after edge 3
        check("multi_e3", 32'(multi_err), 32'd1);
        check("multi_busy", 32'(busy), 32'd0);
        tick(7);                                  // after edge 10
        check("multi_pulses", 32'(pulses - p0), 32'd0);
        btn_add = 1'b0;
        tick(2);                                  // edge 1' : btn_s still two-hot before it
        check("multi_hold", 32'(multi_err), 32'd1);
        tick(1);                                  // edge 2' : IDLE -> PRESS
        check("multi_clear", 32'(multi_err), 32'd0);
        check("div_busy", 32'(busy), 32'd1);
        tick(4);                                  // edge 6'
        check("div_valid", 32'(op_valid), 32'd1);
        check("div_sel", 32'(op_sel), 32'd3);
        tick(3);
        check("div_pulses", 32'(pulses - p0), 32'd1);

        // 5. release with a 2-cycle bounce, then a second genuine press
        p0 = pulses;
        btn_div2 = 1'b0;
        tick(3);                                  // after edge 2: RELEASE entered
        btn_div2 = 1'b1;
        tick(2);
        btn_div2 = 1'b0;
        tick(15);
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check("bounce_busy", 32'(busy), 32'd0);
        btn_div2 = 1'b1;
        tick(8);
        check("repress_pulses", 32'(pulses - p0), 32'd1);
        check("repress_sel", 32'(op_sel), 32'd3);
        btn_div2 = 1'b0;
        tick(10);

        // 6. reset in the middle of a press
        p0 = pulses;
        btn_sub = 1'b1;
        tick(5);                                  // after edge 4: PRESS, cnt=2
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_sel", 32'(op_sel), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        btn_sub = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("mid_rst_pulses", 32'(pulses - p0), 32'd0);
        check("mid_rst_sel_end", 32'(op_sel), 32'd0);

`ifdef OP_CYCLE_EN
        btn_div2 = 1'b1;
        tick(8);
        btn_div2 = 1'b0;
        tick(10);
        check("cyc_pre_sel", 32'(op_sel), 32'd3);
        p0 = pulses;
        btn_next = 1'b1;
        tick(8);
        btn_next = 1'b0;
        tick(10);
        check("cyc_wrap_sel", 32'(op_sel), 32'd0);
        check("cyc_pulses", 32'(pulses - p0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
